ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte to the keyboard (0xED LED set, 0xFF reset, 0xF4 enable).

---
 rtl/ps2_host_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, device-clocked frame, ACK check.
// Optional PS2_TX_RETRY_EN: retry a failed transfer up to RETRY_MAX extra times before reporting tx_err.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 6000,
  parameter int RTS_CYC     = 100,
  parameter int TIMEOUT_CYC = 750000,
  parameter int FILTER_LEN  = 8,
  parameter int RETRY_MAX   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int PH_MAX = (INHIBIT_CYC > RTS_CYC) ? INHIBIT_CYC : RTS_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int FLT_W  = $clog2(FILTER_LEN + 1);
  localparam int BIT_W  = $clog2(10 + 1);

  localparam logic [PH_W-1:0]  INH_LAST = PH_W'(INHIBIT_CYC - 1);
  localparam logic [PH_W-1:0]  RTS_LAST = PH_W'(RTS_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [BIT_W-1:0] STOP_IDX = BIT_W'(9);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE,
    FAIL
  } state_t;

  state_t             state;
  logic               clk_s1, clk_s2, dat_s1, dat_s2;
  logic               clk_f, clk_f_q;
  logic [FLT_W-1:0]   flt_cnt;
  logic [PH_W-1:0]    ph_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic [9:0]         shreg;
  logic               fall;
  logic               tmo_hit;

`ifdef PS2_TX_RETRY_EN
  localparam int RC_W = $clog2(RETRY_MAX + 1);
  logic [RC_W-1:0]    retry_cnt;
  logic [9:0]         frame;
`endif

  // The filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      clk_f   <= 1'b1;
      clk_f_q <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      dat_s1  <= ps2_dat_in;
      dat_s2  <= dat_s1;
      clk_f_q <= clk_f;
      if (clk_s2 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_f   <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall    = clk_f_q & ~clk_f;
  assign tmo_hit = (tmo_cnt >= TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      ph_cnt     <= '0;
      tmo_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt  <= '0;
      frame      <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg      <= {1'b1, ~^tx_data, tx_data};
`ifdef PS2_TX_RETRY_EN
            frame      <= {1'b1, ~^tx_data, tx_data};
            retry_cnt  <= '0;
`endif
            bit_idx    <= '0;
            ph_cnt     <= '0;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= INHIBIT;
          end
        end

        INHIBIT: begin
          ps2_clk_oe <= 1'b1;
          if (ph_cnt == INH_LAST) begin
            ph_cnt     <= '0;
            ps2_dat_oe <= 1'b1;
            state      <= RTS;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        RTS: begin
          if (ph_cnt == RTS_LAST) begin
            ph_cnt     <= '0;
            tmo_cnt    <= '0;
            ps2_clk_oe <= 1'b0;
            state      <= SHIFT;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        // Data changes while the device holds the clock low; the stop bit releases the line.
        SHIFT: begin
          if (tmo_hit) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= FAIL;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (fall) begin
              ps2_dat_oe <= ~shreg[0];
              shreg      <= {1'b1, shreg[9:1]};
              bit_idx    <= bit_idx + 1'b1;
              if (bit_idx == STOP_IDX) state <= ACK;
            end
          end
        end

        ACK: begin
          ps2_dat_oe <= 1'b0;
          if (tmo_hit) begin
            ps2_clk_oe <= 1'b0;
            state      <= FAIL;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (fall) state <= dat_s2 ? FAIL : WAIT_IDLE;
          end
        end

        WAIT_IDLE: begin
          if (tmo_hit) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= FAIL;
          end else if (clk_f && dat_s2) begin
            tx_done  <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        FAIL: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
          if (retry_cnt < RC_W'(RETRY_MAX)) begin
            retry_cnt <= retry_cnt + 1'b1;
            shreg     <= frame;
            bit_idx   <= '0;
            ph_cnt    <= '0;
            state     <= INHIBIT;
          end else begin
            tx_err   <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
`else
          tx_err   <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard bus model on open-drain lines, scoreboard of frame bits and outcomes.
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int RTSC = 10;
  localparam int TMO  = 2000;
  localparam int FLT  = 8;
  localparam int RMAX = 2;
  localparam int H    = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_err;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int         vec_cnt = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0;
  int         last_err_cyc = 0, rel_cyc = 0;
  logic [1:0] oe_after_err = 2'b11;
  bit         err_prev = 1'b0, clk_oe_prev = 1'b0;
  bit         exp_bit_q[$];
  logic [1:0] exp_out_q[$];

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYC(INH),
    .RTS_CYC    (RTSC),
    .TIMEOUT_CYC(TMO),
    .FILTER_LEN (FLT),
    .RETRY_MAX  (RMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse bookkeeping sampled on the falling edge, where DUT outputs are stable.
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_err === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt++;
    if (err_prev) oe_after_err = {ps2_clk_oe, ps2_dat_oe};
    err_prev = (tx_err === 1'b1);
    if (ps2_clk_oe === 1'b1 && !clk_oe_prev) inh_cnt++;
    clk_oe_prev = (ps2_clk_oe === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] d);
    @(negedge clk);
    checkOutput("tx_ready_idle", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    checkOutput("busy_after_accept", busy, 1);
  endtask

  // One attempt of the keyboard side: watch inhibit/RTS, then generate ncl device clocks.
  task automatic deviceRun(input int ncl, input bit ack, input bit glitch, input bit chk_lat);
    int guard = 0;
    int lat = 0;
    bit e;
    do begin
      @(negedge clk);
      guard++;
    end while (ps2_clk_oe !== 1'b1 && guard < 3000);
    if (ps2_clk_oe !== 1'b1) begin
      checkOutput("inhibit_seen", 0, 1);
      return;
    end
    while (ps2_clk_oe === 1'b1 && lat < INH + RTSC + 200) begin
      lat++;
      @(negedge clk);
    end
    if (chk_lat) checkOutput("release_latency", lat, INH + RTSC);
    rel_cyc = cyc;
    checkOutput("start_bit", ps2_dat_in, 0);
    repeat (20) @(negedge clk);
    for (int i = 1; i <= ncl; i++) begin
      if (i == 11 && ack) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      if (i <= 10) begin
        if (exp_bit_q.size() == 0) begin
          checkOutput("bit_queue_empty", 0, 1);
        end else begin
          e = exp_bit_q.pop_front();
          checkOutput($sformatf("frame_bit%0d", i - 1), ps2_dat_in, e);
        end
      end
      dev_clk_low = 1'b0;
      for (int j = 0; j < H; j++) begin
        if (glitch && i <= 10 && j == 15) dev_clk_low = 1'b1;
        if (j == 18) dev_clk_low = 1'b0;
        if (i == 11 && j == H / 2) dev_dat_low = 1'b0;
        @(negedge clk);
      end
    end
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask

  // Drives one command; ncl = 11 full frame, 0 = device silent, otherwise an aborted frame.
  task automatic applyStimulus(input logic [7:0] d, input int ncl, input bit ack,
                               input bit glitch, input bit poke);
    logic [9:0] fr;
    logic [1:0] exp_out;
    int att = 1;
    int d0, e0, wait_n;
    bit fail_exp;
    fr = {1'b1, ~^d, d};
    fail_exp = (ncl == 0) || (ncl == 11 && !ack);
`ifdef PS2_TX_RETRY_EN
    if (fail_exp) att = RMAX + 1;
`endif
    for (int a = 0; a < att; a++)
      for (int b = 0; b < 10 && b < ncl; b++) exp_bit_q.push_back(fr[b]);
    if (ncl == 0 || ncl == 11) exp_out_q.push_back(fail_exp ? 2'b01 : 2'b10);
    d0 = done_cnt;
    e0 = err_cnt;
    sendByte(d);
    fork
      begin
        for (int a = 0; a < att; a++) deviceRun(ncl, ack, glitch, a == 0);
      end
      begin
        if (poke) begin
          repeat (5) @(negedge clk);
          tx_data  = 8'h55;
          tx_valid = 1'b1;
          repeat (3) @(negedge clk);
          tx_valid = 1'b0;
        end
      end
    join
    if (ncl == 0 || ncl == 11) begin
      wait_n = 0;
      while (done_cnt == d0 && err_cnt == e0 && wait_n < TMO + 1000) begin
        @(negedge clk);
        wait_n++;
      end
      repeat (3) @(negedge clk);
      exp_out = exp_out_q.pop_front();
      checkOutput("done_pulses", done_cnt - d0, {31'd0, exp_out[1]});
      checkOutput("err_pulses", err_cnt - e0, {31'd0, exp_out[0]});
    end
  endtask

  initial begin
    int i0;
    int att_nack;
    int e0, d0;
    att_nack = 1;
`ifdef PS2_TX_RETRY_EN
    att_nack = RMAX + 1;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_clk_oe", ps2_clk_oe, 0);
    checkOutput("rst_dat_oe", ps2_dat_oe, 0);
    checkOutput("rst_pulses", {tx_done, tx_err}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    applyStimulus(8'hED, 11, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h01, 11, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h00, 11, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hF4, 11, 1'b1, 1'b1, 1'b0);

    i0 = inh_cnt;
    oe_after_err = 2'b11;
    applyStimulus(8'hFF, 11, 1'b0, 1'b0, 1'b0);
    checkOutput("nack_oe_after_err", oe_after_err, 2'b00);
    checkOutput("nack_inhibit_phases", inh_cnt - i0, att_nack);

    applyStimulus(8'hED, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("tmo_window",
                ((last_err_cyc - rel_cyc) >= TMO && (last_err_cyc - rel_cyc) <= TMO + 2), 1);

    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(8'hF4, 4, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_clk_oe", ps2_clk_oe, 0);
    checkOutput("midrst_dat_oe", ps2_dat_oe, 0);
    checkOutput("midrst_tx_ready", tx_ready, 1);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("midrst_no_done", done_cnt - d0, 0);
    checkOutput("midrst_no_err", err_cnt - e0, 0);

    applyStimulus(8'hFF, 11, 1'b1, 1'b0, 1'b0);

    checkOutput("done_err_overlap", both_cnt, 0);
    checkOutput("bits_left", exp_bit_q.size(), 0);
    checkOutput("outcomes_left", exp_out_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
